// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM states, key map, column drive
// patterns and default parameter values.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam int DEF_SCAN_CYCLES    = 50000;
  localparam int DEF_DEBOUNCE_SCANS = 4;
  localparam int DEF_REPEAT_SCANS   = 100;

  // Nibble {row, col} holds the hex code of that key; row 0 / col 0 is the low nibble.
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  localparam logic [15:0] COL_PATTERNS = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [3:0]  ROWS_IDLE    = 4'b1111;

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    return KEY_MAP[{row, col, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] col_pattern(input logic [1:0] idx);
    return COL_PATTERNS[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic is_single(input logic [3:0] r);
    logic single;
    case (r)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single = 1'b1;
      default:                            single = 1'b0;
    endcase
    return single;
  endfunction

  function automatic logic [1:0] row_index(input logic [3:0] r);
    logic [1:0] idx;
    case (r)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous active-low keypad rows;
// resets to the idle (all released) pattern.
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows_i,
  output logic [3:0] rows_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= ROWS_IDLE;
      sync_q <= ROWS_IDLE;
    end else begin
      meta_q <= rows_i;
      sync_q <= meta_q;
    end
  end

  assign rows_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, press/release debounce and a 4-digit value register.
// Build option: define KEYPAD_AUTOREPEAT_EN to re-strobe a key held for REPEAT_SCANS samples.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES    = DEF_SCAN_CYCLES,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS,
  parameter int REPEAT_SCANS   = DEF_REPEAT_SCANS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  rows,
  input  logic        clear,
  output logic [3:0]  cols,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic [15:0] value
);

  localparam int CW = $clog2(SCAN_CYCLES);
  localparam int DW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [DW-1:0] DB_ONE   = DW'(1);
  localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_SCANS);

  if (SCAN_CYCLES < 4 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : g_bad_params
    $error("keypad_scanner: parameter out of range");
  end

  logic [3:0]    rows_s;
  logic          sample_s;
  logic          single_s;
  logic          same_s;
  logic          idle_s;
  logic [1:0]    next_col_s;
  logic [DW-1:0] dcnt_inc_s;
  logic [DW-1:0] rcnt_inc_s;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    col_q;
  logic [1:0]    row_q;
  logic [3:0]    cols_q;
  logic [DW-1:0] dcnt_q;
  logic [DW-1:0] rcnt_q;
  logic          key_valid_q;
  logic [3:0]    key_code_q;
  logic [15:0]   value_q;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int HW = $clog2(REPEAT_SCANS + 1);
  localparam logic [HW-1:0] REP_ONE  = HW'(1);
  localparam logic [HW-1:0] REP_LAST = HW'(REPEAT_SCANS);
  logic [HW-1:0] hcnt_q;
  logic [HW-1:0] hcnt_inc_s;
  assign hcnt_inc_s = hcnt_q + REP_ONE;
`endif

  keypad_row_sync u_row_sync (
    .clk    (clk),
    .reset  (reset),
    .rows_i (rows),
    .rows_o (rows_s)
  );

  assign sample_s   = (cnt_q == CNT_LAST);
  assign single_s   = is_single(rows_s);
  assign same_s     = single_s && (row_index(rows_s) == row_q);
  assign idle_s     = (rows_s == ROWS_IDLE);
  assign next_col_s = col_q + 2'd1;
  assign dcnt_inc_s = dcnt_q + DB_ONE;
  assign rcnt_inc_s = rcnt_q + DB_ONE;

  // Key strobe/code are registered on entry to PRESSED; value shifts as PRESSED ends.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_SCAN;
      cnt_q       <= {CW{1'b0}};
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cols_q      <= 4'b1110;
      dcnt_q      <= {DW{1'b0}};
      rcnt_q      <= {DW{1'b0}};
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
      value_q     <= 16'h0000;
`ifdef KEYPAD_AUTOREPEAT_EN
      hcnt_q      <= {HW{1'b0}};
`endif
    end else begin
      cnt_q       <= sample_s ? {CW{1'b0}} : cnt_q + CNT_ONE;
      key_valid_q <= 1'b0;
      if (clear) begin
        value_q <= 16'h0000;
      end
      case (state_q)
        ST_SCAN: begin
          if (sample_s) begin
            if (single_s) begin
              row_q  <= row_index(rows_s);
              dcnt_q <= DB_ONE;
              if (DEBOUNCE_SCANS == 32'd1) begin
                state_q     <= ST_PRESSED;
                key_valid_q <= 1'b1;
                key_code_q  <= key_map(row_index(rows_s), col_q);
              end else begin
                state_q <= ST_DEBOUNCE;
              end
            end else begin
              col_q  <= next_col_s;
              cols_q <= col_pattern(next_col_s);
            end
          end
        end
        ST_DEBOUNCE: begin
          if (sample_s) begin
            if (same_s) begin
              dcnt_q <= dcnt_inc_s;
              if (dcnt_inc_s == DB_LAST) begin
                state_q     <= ST_PRESSED;
                key_valid_q <= 1'b1;
                key_code_q  <= key_map(row_q, col_q);
              end
            end else begin
              state_q <= ST_SCAN;
              dcnt_q  <= {DW{1'b0}};
              col_q   <= next_col_s;
              cols_q  <= col_pattern(next_col_s);
            end
          end
        end
        ST_PRESSED: begin
          value_q <= clear ? {12'h000, key_code_q} : {value_q[11:0], key_code_q};
          state_q <= ST_RELEASE;
          rcnt_q  <= {DW{1'b0}};
`ifdef KEYPAD_AUTOREPEAT_EN
          hcnt_q  <= {HW{1'b0}};
`endif
        end
        ST_RELEASE: begin
          if (sample_s) begin
            if (idle_s) begin
              if (rcnt_inc_s == DB_LAST) begin
                state_q <= ST_SCAN;
                rcnt_q  <= {DW{1'b0}};
                col_q   <= next_col_s;
                cols_q  <= col_pattern(next_col_s);
              end else begin
                rcnt_q <= rcnt_inc_s;
              end
            end else begin
              rcnt_q <= {DW{1'b0}};
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            if (same_s) begin
              if (hcnt_inc_s == REP_LAST) begin
                state_q     <= ST_PRESSED;
                key_valid_q <= 1'b1;
                key_code_q  <= key_map(row_q, col_q);
                hcnt_q      <= {HW{1'b0}};
              end else begin
                hcnt_q <= hcnt_inc_s;
              end
            end else begin
              hcnt_q <= {HW{1'b0}};
            end
`endif
          end
        end
        default: begin
          state_q <= ST_SCAN;
        end
      endcase
    end
  end

  assign cols      = cols_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign value     = value_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_CYCLES=8, DEBOUNCE_SCANS=3, REPEAT_SCANS=4.
// A behavioural keypad model drives rows from the scanned columns; builds with or without KEYPAD_AUTOREPEAT_EN.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clear = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] value;

  int checks = 0;
  int fails = 0;
  int strobe_cnt = 0;

  logic       key_en = 1'b0;
  int         key_row = 0;
  int         key_col = 0;
  logic       force_en = 1'b0;
  logic [3:0] force_rows = 4'b1111;

  // Row-major layout of the keypad face.
  logic [3:0] keys [16] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC, 4'h0, 4'hF, 4'hE, 4'hD};

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_CYCLES    (8),
    .DEBOUNCE_SCANS (3),
    .REPEAT_SCANS   (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .clear     (clear),
    .cols      (cols),
    .key_valid (key_valid),
    .key_code  (key_code),
    .value     (value)
  );

  always_comb begin
    rows = 4'b1111;
    if (force_en) begin
      rows = force_rows;
    end else if (key_en && (cols[key_col] == 1'b0)) begin
      rows[key_row] = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (key_valid === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n * 8) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic set_key(input logic [3:0] code);
    for (int i = 0; i < 16; i++) begin
      if (keys[i] == code) begin
        key_row = i / 4;
        key_col = i % 4;
      end
    end
    key_en = 1'b1;
  endtask

  task automatic press_key(input logic [3:0] code);
    int start;
    int guard;
    start = strobe_cnt;
    guard = 0;
    set_key(code);
    while (strobe_cnt == start && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    check("press_code", {12'h000, key_code}, {12'h000, code});
    key_en = 1'b0;
    step(4);
    check("press_once", 16'(strobe_cnt - start), 16'd1);
  endtask

  initial begin
    int base;
    int guard;
    logic [15:0] exp_strobes;
    logic [15:0] exp_hold_value;

    // Reset values and free-running column scan.
    do_reset();
    check("rst_cols", {12'h000, cols}, 16'h000E);
    check("rst_valid", {15'h0000, key_valid}, 16'h0000);
    check("rst_code", {12'h000, key_code}, 16'h0000);
    check("rst_value", value, 16'h0000);
    repeat (7) @(negedge clk);
    #1;
    check("dwell_hold", {12'h000, cols}, 16'h000E);
    @(negedge clk);
    #1;
    check("col1", {12'h000, cols}, 16'h000D);
    step(1);
    check("col2", {12'h000, cols}, 16'h000B);
    step(1);
    check("col3", {12'h000, cols}, 16'h0007);
    step(1);
    check("col_wrap", {12'h000, cols}, 16'h000E);

    // Hold r1c2: accepted on the third matching sample, then held.
    base = strobe_cnt;
    set_key(4'h6);
    step(4);
    check("pre_accept", 16'(strobe_cnt - base), 16'd0);
    step(1);
    check("accept_valid", {15'h0000, key_valid}, 16'h0001);
    check("accept_code", {12'h000, key_code}, 16'h0006);
`ifdef KEYPAD_AUTOREPEAT_EN
    exp_strobes    = 16'd3;
    exp_hold_value = 16'h0666;
`else
    exp_strobes    = 16'd1;
    exp_hold_value = 16'h0006;
`endif
    step(10);
    check("hold_strobes", 16'(strobe_cnt - base), exp_strobes);
    check("hold_value", value, exp_hold_value);
    key_en = 1'b0;
    step(4);

    // Digit entry.
    press_key(4'h1);
    press_key(4'hA);
    press_key(4'h0);
    press_key(4'hF);
    check("value_1A0F", value, 16'h1A0F);
    press_key(4'h5);
    check("value_A0F5", value, 16'hA0F5);

    // clear coinciding with a strobe, then clear alone.
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_key(4'h4);
    check("value_1234", value, 16'h1234);
    set_key(4'h9);
    guard = 0;
    while (key_valid !== 1'b1 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    clear = 1'b1;
    @(negedge clk);
    #1;
    clear = 1'b0;
    check("clear_strobe_value", value, 16'h0009);
    check("clear_strobe_code", {12'h000, key_code}, 16'h0009);
    key_en = 1'b0;
    step(4);
    clear = 1'b1;
    @(negedge clk);
    #1;
    clear = 1'b0;
    check("clear_value", value, 16'h0000);
    check("clear_keeps_code", {12'h000, key_code}, 16'h0009);

    // Bounce and invalid patterns never produce a strobe.
    do_reset();
    base = strobe_cnt;
    force_en = 1'b1;
    force_rows = 4'b1110;
    step(2);
    force_rows = 4'b1111;
    step(2);
    check("bounce_short", 16'(strobe_cnt - base), 16'd0);
    check("bounce_advance", {12'h000, cols}, 16'h000B);
    for (int i = 0; i < 8; i++) begin
      force_rows = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      step(1);
    end
    check("bounce_toggle", 16'(strobe_cnt - base), 16'd0);
    force_rows = 4'b1001;
    step(6);
    check("two_rows_low", 16'(strobe_cnt - base), 16'd0);
    force_en = 1'b0;
    force_rows = 4'b1111;

    // Reset in the middle of DEBOUNCE.
    do_reset();
    base = strobe_cnt;
    set_key(4'h3);
    step(3);
    check("deb_col_held", {12'h000, cols}, 16'h000B);
    step(1);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("deb_rst_cols", {12'h000, cols}, 16'h000E);
    check("deb_rst_valid", {15'h0000, key_valid}, 16'h0000);
    key_en = 1'b0;
    reset = 1'b0;
    step(5);
    check("deb_rst_nostrobe", 16'(strobe_cnt - base), 16'd0);

    // Reset in the middle of RELEASE.
    do_reset();
    base = strobe_cnt;
    set_key(4'h3);
    step(5);
    check("rel_accept_valid", {15'h0000, key_valid}, 16'h0001);
    @(negedge clk);
    #1;
    check("rel_col_held", {12'h000, cols}, 16'h000B);
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("rel_rst_cols", {12'h000, cols}, 16'h000E);
    check("rel_rst_valid", {15'h0000, key_valid}, 16'h0000);
    check("rel_rst_value", value, 16'h0000);
    key_en = 1'b0;
    reset = 1'b0;
    step(5);
    check("rel_rst_strobes", 16'(strobe_cnt - base), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
